// File: rtl/pointing_device_decoder.sv
// pointing_device_decoder: host-side receiver for the CD-i pointing-device byte protocol.
// Captures the post-RTS ID byte, decodes 3-byte motion packets and tracks a clamped cursor.
`default_nettype none

module pointing_device_decoder #(
  parameter int SCREEN_W      = 384,
  parameter int SCREEN_H      = 280,
  parameter int TIMEOUT_TICKS = 300000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rts,
  input  logic [7:0] in_data,
  input  logic       in_write,
  output logic [7:0] device_id,
  output logic       device_valid,
  output logic       pkt_valid,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic       b1,
  output logic       b2,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       sync_err
);

  localparam int                 TW       = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0]      TMR_LAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic signed [11:0] X_MAX12  = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] Y_MAX12  = 12'(SCREEN_H - 1);
  localparam logic [9:0]         X_MAX    = 10'(SCREEN_W - 1);
  localparam logic [9:0]         Y_MAX    = 10'(SCREEN_H - 1);
  localparam logic [9:0]         X_HOME   = 10'(SCREEN_W / 2);
  localparam logic [9:0]         Y_HOME   = 10'(SCREEN_H / 2);

  typedef enum logic [1:0] {
    WAIT_ID = 2'd0,
    IDLE    = 2'd1,
    GOT0    = 2'd2,
    GOT1    = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          err_n, cap_id, lat_b0, lat_x, done;

  // Fields held from byte0/byte1 of the packet in flight
  logic       hold_b1, hold_b2;
  logic [1:0] hold_y76, hold_x76;
  logic [5:0] hold_x50;

  logic [7:0]        dx_new, dy_new;
  logic signed [11:0] sum_x, sum_y;
  logic [9:0]        pos_x_new, pos_y_new;

  always_comb begin
    state_n = state;
    timer_n = timer;
    err_n   = 1'b0;
    cap_id  = 1'b0;
    lat_b0  = 1'b0;
    lat_x   = 1'b0;
    done    = 1'b0;
    if (rts) begin
      state_n = WAIT_ID;
      timer_n = '0;
    end else begin
      case (state)
        WAIT_ID: if (in_write) begin
          cap_id  = 1'b1;
          state_n = IDLE;
        end
        IDLE: if (in_write) begin
          if (in_data[7:6] == 2'b11) begin
            lat_b0  = 1'b1;
            state_n = GOT0;
          end else begin
            err_n = 1'b1;
          end
        end
        GOT0, GOT1: begin
          if (in_write) begin
            timer_n = '0;
            case (in_data[7:6])
              2'b10: begin
                if (state == GOT0) begin
                  lat_x   = 1'b1;
                  state_n = GOT1;
                end else begin
                  done    = 1'b1;
                  state_n = IDLE;
                end
              end
              2'b11: begin
                err_n   = 1'b1;
                lat_b0  = 1'b1;
                state_n = GOT0;
              end
              default: begin
                err_n   = 1'b1;
                state_n = IDLE;
              end
            endcase
          end else if (timer == TMR_LAST) begin
            err_n   = 1'b1;
            timer_n = '0;
            state_n = IDLE;
          end else begin
            timer_n = timer + TW'(1);
          end
        end
        default: state_n = WAIT_ID;
      endcase
    end
  end

  // Sums are wide enough that bit 11 set can only mean a negative result
  assign dx_new = {hold_x76, hold_x50};
  assign dy_new = {hold_y76, in_data[5:0]};
  assign sum_x  = {2'b00, pos_x} + {{4{dx_new[7]}}, dx_new};
  assign sum_y  = {2'b00, pos_y} + {{4{dy_new[7]}}, dy_new};

  always_comb begin
    pos_x_new = sum_x[9:0];
    if (sum_x[11])          pos_x_new = 10'd0;
    else if (sum_x > X_MAX12) pos_x_new = X_MAX;
    pos_y_new = sum_y[9:0];
    if (sum_y[11])          pos_y_new = 10'd0;
    else if (sum_y > Y_MAX12) pos_y_new = Y_MAX;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= WAIT_ID;
      timer        <= '0;
      device_id    <= 8'h00;
      device_valid <= 1'b0;
      pkt_valid    <= 1'b0;
      sync_err     <= 1'b0;
      dx           <= 8'h00;
      dy           <= 8'h00;
      b1           <= 1'b0;
      b2           <= 1'b0;
      pos_x        <= X_HOME;
      pos_y        <= Y_HOME;
      hold_b1      <= 1'b0;
      hold_b2      <= 1'b0;
      hold_y76     <= 2'b00;
      hold_x76     <= 2'b00;
      hold_x50     <= 6'd0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      sync_err  <= err_n;
      pkt_valid <= done;
      if (rts) device_valid <= 1'b0;
      if (cap_id) begin
        device_id    <= in_data;
        device_valid <= 1'b1;
      end
      if (lat_b0) begin
        hold_b1  <= in_data[5];
        hold_b2  <= in_data[4];
        hold_y76 <= in_data[3:2];
        hold_x76 <= in_data[1:0];
      end
      if (lat_x) hold_x50 <= in_data[5:0];
      if (done) begin
        dx    <= dx_new;
        dy    <= dy_new;
        b1    <= hold_b1;
        b2    <= hold_b2;
        pos_x <= pos_x_new;
        pos_y <= pos_y_new;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pointing_device_decoder.sv
// Directed self-checking bench for pointing_device_decoder (short timeout for quick runs).
`default_nettype none

module tb_pointing_device_decoder;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rts = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_write = 1'b0;
  logic [7:0] device_id, dx, dy;
  logic       device_valid, pkt_valid, b1, b2, sync_err;
  logic [9:0] pos_x, pos_y;

  int checks = 0;
  int errors = 0;
  int pkt_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  pointing_device_decoder #(
    .SCREEN_W(384), .SCREEN_H(280), .TIMEOUT_TICKS(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rts(rts), .in_data(in_data), .in_write(in_write),
    .device_id(device_id), .device_valid(device_valid), .pkt_valid(pkt_valid),
    .dx(dx), .dy(dy), .b1(b1), .b2(b2), .pos_x(pos_x), .pos_y(pos_y), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (pkt_valid) pkt_cnt++;
    if (sync_err) err_cnt++;
    if (pkt_valid && sync_err) both_cnt++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_write = 1'b1;
    @(negedge clk);
    in_write = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (device_id !== 8'h00 || device_valid !== 1'b0 || pkt_valid !== 1'b0 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: id=%h dv=%b pv=%b se=%b, want 00 0 0 0", device_id, device_valid, pkt_valid, sync_err);
    end
    checks++;
    if (dx !== 8'h00 || dy !== 8'h00 || b1 !== 1'b0 || b2 !== 1'b0 || pos_x !== 10'd192 || pos_y !== 10'd140) begin
      errors++;
      $display("FAIL reset_motion: dx=%h dy=%h b=%b%b pos=%0d,%0d, want 00 00 00 192,140", dx, dy, b1, b2, pos_x, pos_y);
    end
  endtask

  task automatic test_id;
    int p0, e0;
    p0 = pkt_cnt; e0 = err_cnt;
    rts = 1'b1;
    idle(5);
    // a byte during rts must be ignored
    @(negedge clk); in_data = 8'h77; in_write = 1'b1;
    @(negedge clk); in_write = 1'b0;
    idle(3);
    checks++;
    if (device_valid !== 1'b0 || device_id !== 8'h00) begin
      errors++;
      $display("FAIL id_rts_ignore: dv=%b id=%h, want 0 00", device_valid, device_id);
    end
    rts = 1'b0;
    send_byte(8'hCA);
    checks++;
    if (device_id !== 8'hCA || device_valid !== 1'b1) begin
      errors++;
      $display("FAIL id_capture: id=%h dv=%b, want CA 1", device_id, device_valid);
    end
    checks++;
    if (pkt_cnt != p0 || err_cnt != e0) begin
      errors++;
      $display("FAIL id_no_pulses: pkt=%0d err=%0d, want 0 0", pkt_cnt - p0, err_cnt - e0);
    end
  endtask

  task automatic test_motion;
    int p0;
    p0 = pkt_cnt;
    send_pkt(8'hC0, 8'h88, 8'h80);
    checks++;
    if (pkt_valid !== 1'b1 || pkt_cnt != p0 + 1 || dx !== 8'h08 || dy !== 8'h00 || pos_x !== 10'd200 || pos_y !== 10'd140) begin
      errors++;
      $display("FAIL motion_plus8: pv=%b n=%0d dx=%h dy=%h pos=%0d,%0d, want 1 1 08 00 200,140",
               pkt_valid, pkt_cnt - p0, dx, dy, pos_x, pos_y);
    end
    @(negedge clk);
    checks++;
    if (pkt_valid !== 1'b0 || dx !== 8'h08) begin
      errors++;
      $display("FAIL motion_pulse_hold: pv=%b dx=%h, want 0 08", pkt_valid, dx);
    end
    send_pkt(8'hE3, 8'hB8, 8'h80);
    checks++;
    if (dx !== 8'hF8 || b1 !== 1'b1 || b2 !== 1'b0 || pos_x !== 10'd192) begin
      errors++;
      $display("FAIL motion_minus8: dx=%h b=%b%b pos_x=%0d, want F8 10 192", dx, b1, b2, pos_x);
    end
  endtask

  task automatic test_clamp;
    send_pkt(8'hC2, 8'h80, 8'h80);  // -128 -> 64
    send_pkt(8'hC3, 8'h84, 8'h80);  // -60  -> 4
    checks++;
    if (pos_x !== 10'd4) begin
      errors++;
      $display("FAIL clamp_setup_4: pos_x=%0d, want 4", pos_x);
    end
    send_pkt(8'hE3, 8'hB8, 8'h80);
    checks++;
    if (pos_x !== 10'd0 || dx !== 8'hF8) begin
      errors++;
      $display("FAIL clamp_low_x: pos_x=%0d dx=%h, want 0 F8", pos_x, dx);
    end
    send_pkt(8'hC1, 8'hBF, 8'h80);  // +127
    send_pkt(8'hC1, 8'hBF, 8'h80);  // +127 -> 254
    send_pkt(8'hC1, 8'hBE, 8'h80);  // +126 -> 380
    checks++;
    if (pos_x !== 10'd380) begin
      errors++;
      $display("FAIL clamp_setup_380: pos_x=%0d, want 380", pos_x);
    end
    send_pkt(8'hC0, 8'h88, 8'h80);
    checks++;
    if (pos_x !== 10'd383) begin
      errors++;
      $display("FAIL clamp_high_x: pos_x=%0d, want 383", pos_x);
    end
    send_pkt(8'hD8, 8'h80, 8'h80);  // dy=-128, b2=1
    checks++;
    if (pos_y !== 10'd12 || dy !== 8'h80 || b1 !== 1'b0 || b2 !== 1'b1 || dx !== 8'h00) begin
      errors++;
      $display("FAIL y_minus128: pos_y=%0d dy=%h b=%b%b dx=%h, want 12 80 01 00", pos_y, dy, b1, b2, dx);
    end
    send_pkt(8'hD8, 8'h80, 8'h80);
    checks++;
    if (pos_y !== 10'd0 || pos_x !== 10'd383) begin
      errors++;
      $display("FAIL clamp_low_y: pos=%0d,%0d, want 383,0", pos_x, pos_y);
    end
    send_pkt(8'hC4, 8'h80, 8'hBF);  // dy=+127
    send_pkt(8'hC4, 8'h80, 8'hBF);
    send_pkt(8'hC4, 8'h80, 8'hBF);  // 381 -> 279
    checks++;
    if (pos_y !== 10'd279) begin
      errors++;
      $display("FAIL clamp_high_y: pos_y=%0d, want 279", pos_y);
    end
  endtask

  task automatic test_resync;
    int p0, e0;
    p0 = pkt_cnt; e0 = err_cnt;
    send_byte(8'h88);
    send_byte(8'hC0);
    send_byte(8'hC0);
    send_byte(8'h88);
    send_byte(8'h80);
    idle(2);
    checks++;
    if (err_cnt != e0 + 2 || pkt_cnt != p0 + 1 || dx !== 8'h08 || pos_x !== 10'd383) begin
      errors++;
      $display("FAIL resync: errs=%0d pkts=%0d dx=%h pos_x=%0d, want 2 1 08 383",
               err_cnt - e0, pkt_cnt - p0, dx, pos_x);
    end
  endtask

  task automatic test_timeout;
    int p0, e0;
    p0 = pkt_cnt; e0 = err_cnt;
    send_byte(8'hC0);
    idle(TMO - 2);
    checks++;
    if (err_cnt != e0) begin
      errors++;
      $display("FAIL timeout_early: errs=%0d, want 0", err_cnt - e0);
    end
    idle(4);
    checks++;
    if (err_cnt != e0 + 1) begin
      errors++;
      $display("FAIL timeout_fire: errs=%0d, want 1", err_cnt - e0);
    end
    send_byte(8'h88);
    idle(2);
    checks++;
    if (err_cnt != e0 + 2 || pkt_cnt != p0) begin
      errors++;
      $display("FAIL timeout_idle_after: errs=%0d pkts=%0d, want 2 0", err_cnt - e0, pkt_cnt - p0);
    end
  endtask

  task automatic test_abort;
    int p0, e0;
    p0 = pkt_cnt; e0 = err_cnt;
    send_byte(8'hC0);
    send_byte(8'h88);
    rts = 1'b1;
    idle(3);
    checks++;
    if (device_valid !== 1'b0 || device_id !== 8'hCA || pos_x !== 10'd383 || pos_y !== 10'd279 || dx !== 8'h08) begin
      errors++;
      $display("FAIL rts_abort: dv=%b id=%h pos=%0d,%0d dx=%h, want 0 CA 383,279 08",
               device_valid, device_id, pos_x, pos_y, dx);
    end
    rts = 1'b0;
    send_byte(8'h5A);
    send_byte(8'h80);  // would complete a packet if the partial survived
    idle(2);
    checks++;
    if (device_id !== 8'h5A || device_valid !== 1'b1 || pkt_cnt != p0 || err_cnt != e0 + 1) begin
      errors++;
      $display("FAIL rts_drop_partial: id=%h dv=%b pkts=%0d errs=%0d, want 5A 1 0 1",
               device_id, device_valid, pkt_cnt - p0, err_cnt - e0);
    end
    send_byte(8'hC0);
    send_byte(8'h88);
    #2 reset_n = 1'b0;
    idle(2);
    checks++;
    if (device_id !== 8'h00 || device_valid !== 1'b0 || dx !== 8'h00 || pos_x !== 10'd192 || pos_y !== 10'd140 || pkt_cnt != p0) begin
      errors++;
      $display("FAIL reset_abort: id=%h dv=%b dx=%h pos=%0d,%0d pkts=%0d, want 00 0 00 192,140 0",
               device_id, device_valid, dx, pos_x, pos_y, pkt_cnt - p0);
    end
    reset_n = 1'b1;
    send_byte(8'h80);  // post-reset: in WAIT_ID this is taken as the ID
    checks++;
    if (device_id !== 8'h80 || device_valid !== 1'b1 || pkt_cnt != p0) begin
      errors++;
      $display("FAIL reset_state_waitid: id=%h dv=%b pkts=%0d, want 80 1 0", device_id, device_valid, pkt_cnt - p0);
    end
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL exclusive_pulses: overlaps=%0d, want 0", both_cnt);
    end
  endtask

  initial begin
    idle(3);
    test_reset;
    reset_n = 1'b1;
    test_id;
    test_motion;
    test_clamp;
    test_resync;
    test_timeout;
    test_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
